verification: RTL and testbench
===============================

# verification

Free-running synchronous up-counter with a parameterizable width and terminal value. It provides a cycle count, a terminal-count flag and a one-cycle wrap pulse for sequencing and timeout logic. The first three ports are positional-compatible (clk, rst, count), so the block can be instantiated with only those three ports and the status outputs left unconnected.

## Interface

Parameters:

- WIDTH, 4: counter width in bits; must be ≥ 1.
- MAX_COUNT, 2**WIDTH-1: terminal value; must satisfy 0 < MAX_COUNT ≤ 2**WIDTH-1. An out-of-range value is an elaboration error (generate-time check).

Ports:

- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: reset, synchronous, active-high.
- count, output, WIDTH: current count value, registered.
- tc, output, 1: terminal count; high while count == MAX_COUNT (combinational decode of the register).
- wrap, output, 1: registered pulse; high for exactly one cycle after count rolls over from MAX_COUNT to 0.

No other inputs exist. The counter has no enable, no load and no direction control.

## Operation

- Reset, sampled at a rising clk edge with rst = 1:
  - count ← 0
  - wrap ← 0
  - tc therefore follows as (MAX_COUNT == 0), which is always 0 given the legal range.
- Normal operation, with rst = 0 at the rising edge:
  - If count == MAX_COUNT: count ← 0 and wrap ← 1.
  - Otherwise: count ← count + 1 and wrap ← 0.
- Arithmetic is unsigned with modulo MAX_COUNT+1. With the default MAX_COUNT, this is natural WIDTH-bit rollover (15 → 0 for WIDTH = 4).
- count never exceeds MAX_COUNT after the first reset.
- Reset has priority over counting. Asserting rst mid-sequence, including on the exact edge where a wrap would occur, forces count = 0 and wrap = 0. No wrap pulse is generated for that edge.
- Before the first reset, count and wrap are undefined (X in simulation). Users must apply rst for at least one rising edge.
- Holding rst for multiple cycles keeps count at 0.

## Timing

- Latency: count changes exactly once per rising edge; the value is visible after the edge (non-blocking update).
- First edge with rst = 0 after reset gives count = 1. The N-th edge after reset release gives count = N mod (MAX_COUNT+1).
- tc is combinational from count, so it is high during the same cycle in which count == MAX_COUNT.
- wrap is high during the same cycle in which count == 0 following a rollover, i.e. the cycle after tc was high. The pair (tc then wrap) always appears on consecutive cycles when there is no reset.
- Period of count and of wrap is MAX_COUNT+1 cycles. wrap duty cycle is 1/(MAX_COUNT+1).
- No combinational path exists from rst to any output. The rst effect appears only after the clock edge.

## Test plan

- **Reset hold:** clk period 10 ns, rst = 1 for 20 ns (edges at 5 ns and 15 ns) -> count = 0, tc = 0, wrap = 0 after each edge.
- **Count-up:** release rst at 20 ns -> count = 1 at 25 ns, 2 at 35 ns, …, 15 at 165 ns with tc = 1 only during that cycle.
- **Rollover:** continue from count = 15 -> at 175 ns count = 0 and wrap = 1 for exactly one cycle; at 185 ns count = 1 and wrap = 0.
- **Long run:** 50 edges after reset release (to ~520 ns) -> count = 50 mod 16 = 2, and exactly 3 wrap pulses observed.
- **Mid-run reset:** assert rst for one edge while count = 9 -> count = 0 and wrap = 0 next cycle; counting resumes at 1. Then assert rst on the edge where count = 15 -> count = 0 with no wrap pulse.
- **Parameter variant:** WIDTH = 4, MAX_COUNT = 9 -> sequence 0…9, 0; tc high at 9; wrap high at the following 0; count never reaches 10.

Source files
------------

// File: rtl/verification.sv
// Free-running modulo-(MAX_COUNT+1) up-counter with terminal-count decode
// and a one-cycle registered wrap pulse.
module verification #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  // Reject illegal parameterisations at elaboration rather than silently truncating.
  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("verification: WIDTH must be >= 1");
    end
    if (MAX_COUNT < 1 || MAX_COUNT > (2**WIDTH) - 1) begin : g_bad_max
      $error("verification: MAX_COUNT must satisfy 0 < MAX_COUNT <= 2**WIDTH-1");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_VAL = MAX_COUNT[WIDTH-1:0];

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             w_at_max;

  assign w_at_max = (r_count == MAX_VAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (w_at_max) begin
      r_count <= '0;
      r_wrap  <= 1'b1;
    end else begin
      r_count <= r_count + WIDTH'(1);
      r_wrap  <= 1'b0;
    end
  end

  assign count = r_count;
  assign tc    = w_at_max;
  assign wrap  = r_wrap;

endmodule

// File: tb/tb_verification.sv
// Scoreboard bench: default (0..15) and MAX_COUNT=9 counters share clk/rst;
// each driven edge pushes the model's expected outputs, popped after the edge.
module tb_verification;

  logic       clk;
  logic       rst;
  logic [3:0] count_a, count_b;
  logic       tc_a, tc_b, wrap_a, wrap_b;

  int checks = 0;
  int errors = 0;

  verification #(.WIDTH(4)) u_dut_a (
    .clk(clk), .rst(rst), .count(count_a), .tc(tc_a), .wrap(wrap_a)
  );

  verification #(.WIDTH(4), .MAX_COUNT(9)) u_dut_b (
    .clk(clk), .rst(rst), .count(count_b), .tc(tc_b), .wrap(wrap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] ca;
    logic       ta;
    logic       wa;
    logic [3:0] cb;
    logic       tb_;
    logic       wb;
  } exp_t;

  exp_t sb[$];

  int m_a, m_b;
  bit w_a, w_b;
  int wraps_a, wraps_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r);
    exp_t e;
    exp_t g;
    rst = r;
    if (r) begin
      m_a = 0; w_a = 1'b0;
      m_b = 0; w_b = 1'b0;
    end else begin
      if (m_a == 15) begin m_a = 0; w_a = 1'b1; end
      else begin m_a = m_a + 1; w_a = 1'b0; end
      if (m_b == 9) begin m_b = 0; w_b = 1'b1; end
      else begin m_b = m_b + 1; w_b = 1'b0; end
    end
    e.ca  = 4'(m_a);
    e.ta  = (m_a == 15);
    e.wa  = w_a;
    e.cb  = 4'(m_b);
    e.tb_ = (m_b == 9);
    e.wb  = w_b;
    sb.push_back(e);
    @(posedge clk);
    #1;
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      g = sb.pop_front();
      chk("count_a", 32'(count_a), 32'(g.ca));
      chk("tc_a",    32'(tc_a),    32'(g.ta));
      chk("wrap_a",  32'(wrap_a),  32'(g.wa));
      chk("count_b", 32'(count_b), 32'(g.cb));
      chk("tc_b",    32'(tc_b),    32'(g.tb_));
      chk("wrap_b",  32'(wrap_b),  32'(g.wb));
    end
    chk("b_in_range", 32'(count_b <= 4'd9), 32'd1);
    if (wrap_a === 1'b1) wraps_a++;
    if (wrap_b === 1'b1) wraps_b++;
    $display("t=%0t rst=%0b A: count=%0d tc=%0b wrap=%0b | B: count=%0d tc=%0b wrap=%0b",
             $time, r, count_a, tc_a, wrap_a, count_b, tc_b, wrap_b);
  endtask

  initial begin
    m_a = 0; m_b = 0; w_a = 1'b0; w_b = 1'b0;
    rst = 1'b1;

    // Reset hold: two edges with rst high.
    step(1'b1);
    step(1'b1);
    chk("reset_count_a", 32'(count_a), 32'd0);

    // Count-up, rollover and long run: 50 edges after release.
    wraps_a = 0; wraps_b = 0;
    for (int i = 0; i < 50; i++) begin
      step(1'b0);
      if (i == 14) chk("tc_at_15", 32'(tc_a), 32'd1);
      if (i == 15) chk("wrap_after_15", 32'(wrap_a), 32'd1);
      if (i == 16) chk("wrap_one_cycle", 32'(wrap_a), 32'd0);
    end
    chk("long_count_a", 32'(count_a), 32'd2);
    chk("long_wraps_a", 32'(wraps_a), 32'd3);
    chk("long_count_b", 32'(count_b), 32'd0);
    chk("long_wraps_b", 32'(wraps_b), 32'd5);

    // Mid-run reset at count 9 (bounded search).
    for (int i = 0; i < 20 && m_a != 9; i++) step(1'b0);
    chk("reached_9", 32'(count_a), 32'd9);
    step(1'b1);
    chk("midrst_count", 32'(count_a), 32'd0);
    chk("midrst_wrap", 32'(wrap_a), 32'd0);
    step(1'b0);
    chk("resume_count", 32'(count_a), 32'd1);

    // Reset on the edge where a wrap would occur.
    for (int i = 0; i < 20 && m_a != 15; i++) step(1'b0);
    chk("reached_15", 32'(count_a), 32'd15);
    step(1'b1);
    chk("rst_on_wrap_count", 32'(count_a), 32'd0);
    chk("rst_on_wrap_nowrap", 32'(wrap_a), 32'd0);

    // Parameter variant through a full cycle plus rollover.
    for (int i = 0; i < 11; i++) step(1'b0);
    chk("b_after_11", 32'(count_b), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
